// File: rtl/matrix_mult_pkg.sv
// Shared types and constants for the matrix-mult buffer subsystem.
//   arb_state_e  : buffer port arbiter ownership state
//   mem_req_t    : one requester's SRAM access (default 64-bit / 256-word buffer)
//   ARB_MAX_WAIT : default starvation bound for the external port
package matrix_mult_pkg;

  localparam int unsigned ARB_MAX_WAIT = 8;
  localparam int unsigned ARB_WIDTH    = 64;
  localparam int unsigned ARB_ADDR_W   = 8;

  typedef enum logic [1:0] {
    SHARED    = 2'd0,
    LOCK_PEND = 2'd1,
    LOCKED    = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_WIDTH-1:0]  wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating event counter with synchronous clear.
//   clk_i, rst_async_i : clock, asynchronous active-high reset
//   inc_i              : count this cycle (ignored once at SAT)
//   clr_i              : clear to zero (wins over inc_i)
//   cnt_o              : current count
module arb_wait_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned SAT   = 8
) (
  input  logic             clk_i,
  input  logic             rst_async_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != CNT_W'(SAT))) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/buf_mem_port_arbiter.sv
// Cycle-by-cycle arbiter sharing one single-port buffer SRAM between the
// matrix-mult core and the external/host loader, with host lock handshake.
//   clk_i, rst_async_i        : clock, asynchronous active-high reset
//   core_* / ext_*            : requester ports (req/we/addr/wdata in,
//                               combinational gnt, registered rvalid, rdata)
//   ext_lock_i/ext_lock_ack_o : host exclusive-ownership request / ack
//   mem_*                     : SRAM macro pins (active-low cenb/wenb)
//   conflict_cnt_o            : saturating count of both-request cycles
module buf_mem_port_arbiter
  import matrix_mult_pkg::*;
#(
  parameter  int unsigned WIDTH    = 64,
  parameter  int unsigned SIZE     = 256,
  parameter  int unsigned MAX_WAIT = ARB_MAX_WAIT,
  localparam int unsigned ADDR_W   = $clog2(SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_async_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [WIDTH-1:0]  core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [WIDTH-1:0]  core_rdata_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [WIDTH-1:0]  ext_wdata_i,
  output logic              ext_gnt_o,
  output logic              ext_rvalid_o,
  output logic [WIDTH-1:0]  ext_rdata_o,
  input  logic              ext_lock_i,
  output logic              ext_lock_ack_o,
  output logic              mem_cenb_o,
  output logic              mem_wenb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]  mem_d_o,
  input  logic [WIDTH-1:0]  mem_q_i,
  output logic [15:0]       conflict_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ext_force;
  logic              arb_en;

  // Grants are combinational, so they are forced off while reset is held
  // to keep every output at its reset value immediately.
  assign arb_en    = ~rst_async_i;
  assign ext_force = (wait_cnt >= WAIT_W'(MAX_WAIT));

  // Starvation counter for the external port.
  arb_wait_counter #(
    .CNT_W (WAIT_W),
    .SAT   (MAX_WAIT)
  ) u_wait_cnt (
    .clk_i       (clk_i),
    .rst_async_i (rst_async_i),
    .inc_i       (ext_req_i & ~ext_gnt_o),
    .clr_i       (~ext_req_i | ext_gnt_o),
    .cnt_o       (wait_cnt)
  );

  // Both-request cycle counter, any state.
  arb_wait_counter #(
    .CNT_W (16),
    .SAT   (32'h0000_FFFF)
  ) u_conflict_cnt (
    .clk_i       (clk_i),
    .rst_async_i (rst_async_i),
    .inc_i       (core_req_i & ext_req_i),
    .clr_i       (1'b0),
    .cnt_o       (conflict_cnt_o)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      state_q <= SHARED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; LOCK_PEND always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHARED:    if (ext_lock_i) state_d = LOCK_PEND;
      LOCK_PEND: state_d = ext_lock_i ? LOCKED : SHARED;
      LOCKED:    if (!ext_lock_i) state_d = SHARED;
      default:   state_d = SHARED;
    endcase
  end

  // Output logic: grant selection, SRAM pin mux and lock ack.
  always_comb begin
    core_gnt_o     = 1'b0;
    ext_gnt_o      = 1'b0;
    mem_cenb_o     = 1'b1;
    mem_wenb_o     = 1'b1;
    mem_addr_o     = '0;
    mem_d_o        = '0;
    ext_lock_ack_o = (state_q == LOCKED);

    if (arb_en) begin
      unique case (state_q)
        SHARED: begin
          // Core has priority unless ext has hit its wait bound.
          if (ext_req_i && (!core_req_i || ext_force)) begin
            ext_gnt_o = 1'b1;
          end else if (core_req_i) begin
            core_gnt_o = 1'b1;
          end
        end
        LOCK_PEND, LOCKED: ext_gnt_o = ext_req_i;
        default: ;
      endcase
    end

    if (core_gnt_o) begin
      mem_cenb_o = 1'b0;
      mem_wenb_o = ~core_we_i;
      mem_addr_o = core_addr_i;
      mem_d_o    = core_wdata_i;
    end else if (ext_gnt_o) begin
      mem_cenb_o = 1'b0;
      mem_wenb_o = ~ext_we_i;
      mem_addr_o = ext_addr_i;
      mem_d_o    = ext_wdata_i;
    end
  end

  // Tag the read owner at the grant edge; rvalid pulses the next cycle.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      core_rvalid_o <= 1'b0;
      ext_rvalid_o  <= 1'b0;
    end else begin
      core_rvalid_o <= core_gnt_o & ~core_we_i;
      ext_rvalid_o  <= ext_gnt_o & ~ext_we_i;
    end
  end

  assign core_rdata_o = mem_q_i;
  assign ext_rdata_o  = mem_q_i;

  a_one_grant : assert property (@(posedge clk_i) disable iff (rst_async_i)
    !(core_gnt_o && ext_gnt_o));

  a_no_core_when_locked : assert property (@(posedge clk_i) disable iff (rst_async_i)
    !(core_gnt_o && ext_lock_ack_o));

endmodule

// File: tb/tb_buf_mem_port_arbiter.sv
module tb_buf_mem_port_arbiter;
  import matrix_mult_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_async_i;
  mem_req_t    core_s, ext_s;
  logic        ext_lock_i;
  logic        core_gnt_o, core_rvalid_o, ext_gnt_o, ext_rvalid_o, ext_lock_ack_o;
  logic [63:0] core_rdata_o, ext_rdata_o, mem_d_o, mem_q_i;
  logic        mem_cenb_o, mem_wenb_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] conflict_cnt_o;

  logic [63:0] sram [256];

  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } rd_exp_t;

  rd_exp_t     core_q[$];
  rd_exp_t     ext_q[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  buf_mem_port_arbiter dut (
    .clk_i          (clk_i),
    .rst_async_i    (rst_async_i),
    .core_req_i     (core_s.req),
    .core_we_i      (core_s.we),
    .core_addr_i    (core_s.addr),
    .core_wdata_i   (core_s.wdata),
    .core_gnt_o     (core_gnt_o),
    .core_rvalid_o  (core_rvalid_o),
    .core_rdata_o   (core_rdata_o),
    .ext_req_i      (ext_s.req),
    .ext_we_i       (ext_s.we),
    .ext_addr_i     (ext_s.addr),
    .ext_wdata_i    (ext_s.wdata),
    .ext_gnt_o      (ext_gnt_o),
    .ext_rvalid_o   (ext_rvalid_o),
    .ext_rdata_o    (ext_rdata_o),
    .ext_lock_i     (ext_lock_i),
    .ext_lock_ack_o (ext_lock_ack_o),
    .mem_cenb_o     (mem_cenb_o),
    .mem_wenb_o     (mem_wenb_o),
    .mem_addr_o     (mem_addr_o),
    .mem_d_o        (mem_d_o),
    .mem_q_i        (mem_q_i),
    .conflict_cnt_o (conflict_cnt_o)
  );

  // Single-port SRAM macro model, one-cycle read latency.
  always @(posedge clk_i) begin
    if (!mem_cenb_o) begin
      if (!mem_wenb_o) sram[mem_addr_o] <= mem_d_o;
      else             mem_q_i <= sram[mem_addr_o];
    end
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected read whenever rvalid is seen, and flags reads
  // whose due cycle passed without rvalid.
  always @(negedge clk_i) begin
    rd_exp_t e;
    if (core_rvalid_o) begin
      if (core_q.size() == 0) chk("core_rvalid_unexpected", 64'(core_rvalid_o), 64'd0);
      else begin
        e = core_q.pop_front();
        chk("core_rdata", core_rdata_o, e.data);
        chk("core_rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (core_q.size() != 0 && core_q[0].due <= cyc) begin
      e = core_q.pop_front();
      chk("core_rvalid_missing", 64'(core_rvalid_o), 64'd1);
    end
    if (ext_rvalid_o) begin
      if (ext_q.size() == 0) chk("ext_rvalid_unexpected", 64'(ext_rvalid_o), 64'd0);
      else begin
        e = ext_q.pop_front();
        chk("ext_rdata", ext_rdata_o, e.data);
        chk("ext_rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (ext_q.size() != 0 && ext_q[0].due <= cyc) begin
      e = ext_q.pop_front();
      chk("ext_rvalid_missing", 64'(ext_rvalid_o), 64'd1);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic core_set(input logic req, input logic we, input logic [7:0] addr, input logic [63:0] d);
    core_s.req = req; core_s.we = we; core_s.addr = addr; core_s.wdata = d;
  endtask

  task automatic ext_set(input logic req, input logic we, input logic [7:0] addr, input logic [63:0] d);
    ext_s.req = req; ext_s.we = we; ext_s.addr = addr; ext_s.wdata = d;
  endtask

  task automatic push_core(input logic [63:0] d);
    rd_exp_t e;
    e.data = d; e.due = cyc + 1;
    core_q.push_back(e);
  endtask

  task automatic push_ext(input logic [63:0] d);
    rd_exp_t e;
    e.data = d; e.due = cyc + 1;
    ext_q.push_back(e);
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_core_gnt"}, 64'(core_gnt_o), 64'd0);
    chk({tag, "_ext_gnt"},  64'(ext_gnt_o), 64'd0);
    chk({tag, "_cenb"},     64'(mem_cenb_o), 64'd1);
    chk({tag, "_wenb"},     64'(mem_wenb_o), 64'd1);
    chk({tag, "_addr"},     64'(mem_addr_o), 64'd0);
    chk({tag, "_d"},        mem_d_o, 64'd0);
    chk({tag, "_ack"},      64'(ext_lock_ack_o), 64'd0);
    chk({tag, "_conflict"}, 64'(conflict_cnt_o), 64'd0);
    chk({tag, "_core_rv"},  64'(core_rvalid_o), 64'd0);
    chk({tag, "_ext_rv"},   64'(ext_rvalid_o), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 64'd0;
    mem_q_i     = 64'd0;
    rst_async_i = 1'b1;
    ext_lock_i  = 1'b0;
    core_set(1'b0, 1'b0, 8'd0, 64'd0);
    ext_set(1'b0, 1'b0, 8'd0, 64'd0);
    repeat (3) @(posedge clk_i);
    #1;
    chk_idle_pins("reset");
    #2 rst_async_i = 1'b0;

    // Preload addr 5 and addr 3 through the core port.
    step(); core_set(1'b1, 1'b1, 8'd5, 64'hA5A5);
    #1 chk("pre5_gnt", 64'(core_gnt_o), 64'd1);
    chk("pre5_wenb", 64'(mem_wenb_o), 64'd0);
    step(); core_set(1'b1, 1'b1, 8'd3, 64'h3333);
    #1 chk("pre3_gnt", 64'(core_gnt_o), 64'd1);
    step(); core_set(1'b0, 1'b0, 8'd0, 64'd0);

    // 1: lone core read.
    step(); core_set(1'b1, 1'b0, 8'd5, 64'd0);
    #1 chk("t1_gnt", 64'(core_gnt_o), 64'd1);
    chk("t1_cenb", 64'(mem_cenb_o), 64'd0);
    chk("t1_wenb", 64'(mem_wenb_o), 64'd1);
    chk("t1_addr", 64'(mem_addr_o), 64'd5);
    push_core(64'hA5A5);
    step(); core_set(1'b0, 1'b0, 8'd0, 64'd0);
    chk("t1_core_rv", 64'(core_rvalid_o), 64'd1);
    chk("t1_ext_rv", 64'(ext_rvalid_o), 64'd0);

    // 2: continuous conflict, 8:1 pattern.
    for (int i = 0; i < 20; i++) begin
      step();
      core_set(1'b1, 1'b0, 8'd5, 64'd0);
      ext_set(1'b1, 1'b0, 8'd3, 64'd0);
      #1;
      if ((i % 9) == 8) begin
        chk("t2_ext_gnt", 64'(ext_gnt_o), 64'd1);
        chk("t2_core_gnt_off", 64'(core_gnt_o), 64'd0);
        push_ext(64'h3333);
      end else begin
        chk("t2_core_gnt", 64'(core_gnt_o), 64'd1);
        chk("t2_ext_gnt_off", 64'(ext_gnt_o), 64'd0);
        push_core(64'hA5A5);
      end
    end
    step(); core_set(1'b0, 1'b0, 8'd0, 64'd0); ext_set(1'b0, 1'b0, 8'd0, 64'd0);
    chk("t2_conflict", 64'(conflict_cnt_o), 64'd20);

    // 3: ext write loses to core read, lands next cycle, reads back.
    step(); core_set(1'b1, 1'b0, 8'd3, 64'd0); ext_set(1'b1, 1'b1, 8'd9, 64'h1234);
    #1 chk("t3_core_gnt", 64'(core_gnt_o), 64'd1);
    chk("t3_ext_wait", 64'(ext_gnt_o), 64'd0);
    push_core(64'h3333);
    step(); core_set(1'b0, 1'b0, 8'd0, 64'd0);
    #1 chk("t3_ext_gnt", 64'(ext_gnt_o), 64'd1);
    chk("t3_wenb", 64'(mem_wenb_o), 64'd0);
    chk("t3_addr", 64'(mem_addr_o), 64'd9);
    chk("t3_d", mem_d_o, 64'h1234);
    step(); ext_set(1'b1, 1'b0, 8'd9, 64'd0);
    #1 chk("t3_rb_gnt", 64'(ext_gnt_o), 64'd1);
    push_ext(64'h1234);
    step(); ext_set(1'b0, 1'b0, 8'd0, 64'd0);

    // 4: lock raised with a core read in flight.
    step(); core_set(1'b1, 1'b0, 8'd5, 64'd0); ext_lock_i = 1'b1;
    #1 chk("t4_core_gnt", 64'(core_gnt_o), 64'd1);
    push_core(64'hA5A5);
    step(); core_set(1'b1, 1'b0, 8'd3, 64'd0);
    #1 chk("t4_pend_core_gnt", 64'(core_gnt_o), 64'd0);
    chk("t4_pend_ack", 64'(ext_lock_ack_o), 64'd0);
    step();
    chk("t4_locked_ack", 64'(ext_lock_ack_o), 64'd1);

    // 5: bulk load under lock, then release.
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      ext_set(1'b1, 1'b1, 8'(16 + i), 64'hB000 + 64'(i));
      #1 chk("t5_bulk_ext_gnt", 64'(ext_gnt_o), 64'd1);
      chk("t5_bulk_core_gnt", 64'(core_gnt_o), 64'd0);
    end
    step(); ext_set(1'b0, 1'b0, 8'd0, 64'd0); ext_lock_i = 1'b0;
    #1 chk("t5_ack_held", 64'(ext_lock_ack_o), 64'd1);
    chk("t5_core_blocked", 64'(core_gnt_o), 64'd0);
    step();
    chk("t5_ack_drop", 64'(ext_lock_ack_o), 64'd0);
    chk("t5_core_gnt", 64'(core_gnt_o), 64'd1);
    chk("t5_core_addr", 64'(mem_addr_o), 64'd3);
    push_core(64'h3333);
    step(); core_set(1'b0, 1'b0, 8'd0, 64'd0); ext_set(1'b1, 1'b0, 8'd16, 64'd0);
    #1 chk("t5_rb16_gnt", 64'(ext_gnt_o), 64'd1);
    push_ext(64'hB000);
    step(); ext_set(1'b1, 1'b0, 8'd31, 64'd0);
    #1 chk("t5_rb31_gnt", 64'(ext_gnt_o), 64'd1);
    push_ext(64'hB00F);
    step(); ext_set(1'b0, 1'b0, 8'd0, 64'd0);
    step();
    chk("t5_conflict", 64'(conflict_cnt_o), 64'd37);

    // 6: reset between read grant and rvalid edge.
    step(); core_set(1'b1, 1'b0, 8'd5, 64'd0);
    #1 chk("t6_core_gnt", 64'(core_gnt_o), 64'd1);
    #1 rst_async_i = 1'b1;
    #1 chk_idle_pins("t6_rst");
    core_set(1'b0, 1'b0, 8'd0, 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_async_i = 1'b0;
    step();
    chk("t6_no_rvalid", 64'(core_rvalid_o), 64'd0);
    chk("t6_ack", 64'(ext_lock_ack_o), 64'd0);
    core_set(1'b1, 1'b0, 8'd5, 64'd0);
    #1 chk("t6_shared_gnt", 64'(core_gnt_o), 64'd1);
    push_core(64'hA5A5);
    step(); core_set(1'b0, 1'b0, 8'd0, 64'd0);

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 5 && (core_q.size() != 0 || ext_q.size() != 0); i++) step();
    chk("core_q_drained", 64'(core_q.size()), 64'd0);
    chk("ext_q_drained", 64'(ext_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buf_mem_port_arbiter.md
Name: buf_mem_port_arbiter

Overview:
Shares one single-port buffer SRAM (input, weight or output buffer) between two requesters: the matrix-mult core (sequencer side) and the external/host loader port. It replaces the static ext_en mux with a cycle-by-cycle arbiter. The core has default priority, and an anti-starvation counter bounds how long the external side can wait. An exclusive lock handshake gives the host sole ownership for bulk load and readback. One instance sits in front of each buffer macro in the wrapper.

Parameters:
WIDTH, 64, SRAM word width in bits (ROW*8 or COL*8 per buffer)
SIZE, 256, SRAM depth in words
ADDR_W, $clog2(SIZE), address width (derived; do not override)
MAX_WAIT, 8, maximum number of consecutive cycles an external request can be denied before it is forced to win

Ports:
clk_i  in  1  clock; SRAM and arbiter both sample on the rising edge
rst_async_i  in  1  asynchronous reset, active high
core_req_i  in  1  core access request, single-cycle
core_we_i  in  1  1 = write, 0 = read
core_addr_i  in  ADDR_W  core address
core_wdata_i  in  WIDTH  core write data
core_gnt_o  out  1  core access issued this cycle (combinational)
core_rvalid_o  out  1  core read data valid on core_rdata_o (registered)
core_rdata_o  out  WIDTH  read data, equal to mem_q_i
ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_gnt_o, ext_rvalid_o, ext_rdata_o  same directions, widths and meanings as the core set, for the external side
ext_lock_i  in  1  host requests exclusive ownership (level)
ext_lock_ack_o  out  1  exclusive ownership held (registered)
mem_cenb_o  out  1  SRAM chip enable, active low
mem_wenb_o  out  1  SRAM write enable, active low
mem_addr_o  out  ADDR_W  SRAM address
mem_d_o  out  WIDTH  SRAM write data
mem_q_i  in  WIDTH  SRAM read data, valid one cycle after a read is issued
conflict_cnt_o  out  16  number of cycles with both requests asserted; saturates at 16'hFFFF

Behaviour:
- Reset values: all gnt/rvalid/ack outputs = 0; mem_cenb_o = 1; mem_wenb_o = 1; mem_addr_o = 0; mem_d_o = 0; conflict_cnt_o = 0; FSM = SHARED; wait_cnt = 0.
- At most one grant per cycle. A grant is a combinational function of the requests and registered state.
- Granted cycle: mem_cenb_o = 0, mem_wenb_o = ~we, addr and data come from the winner.
- No grant: cenb = 1, wenb = 1, addr = 0, data = 0.
- Read latency is 1 cycle. The owner of a read is registered at the grant edge, and the matching *_rvalid_o pulses the following cycle. Writes never produce rvalid.
- *_rdata_o = mem_q_i for both sides. Data is meaningful only while the matching rvalid is high.
- FSM states:
  - SHARED: the core wins on a conflict unless wait_cnt >= MAX_WAIT, in which case ext wins. A lone requester always wins. On ext_lock_i = 1, go to LOCK_PEND.
  - LOCK_PEND (exactly 1 cycle): no new core grants; ext may be granted. Lets an in-flight core read return its rvalid. Go to LOCKED if ext_lock_i is still high, else SHARED.
  - LOCKED: ext_lock_ack_o = 1 and core_gnt_o = 0. ext_lock_i = 0 returns to SHARED the next cycle, with ack dropping at that same edge.
- wait_cnt: increments (saturating) on each cycle with ext_req_i & ~ext_gnt_o. It clears on an ext grant or when ext_req_i = 0. Ext therefore waits at most MAX_WAIT cycles.
- A core request denied in LOCK_PEND/LOCKED simply stays pending. Requesters hold req/addr/data until granted.
- conflict_cnt_o increments on core_req_i & ext_req_i in any state and saturates.
- Asynchronous reset mid-operation aborts any pending rvalid (it is not issued after reset) and releases the lock. SRAM contents are not touched.
- Assertions:
  - core_gnt_o & ext_gnt_o never both high.
  - core_gnt_o is never high while ext_lock_ack_o is high.

Decomposition:
- Shared package matrix_mult_pkg gains:
  - arb_state_e enum {SHARED, LOCK_PEND, LOCKED}
  - mem_req_struct {req, we, addr, wdata}, reusable for both requester ports
  - constant ARB_MAX_WAIT
- One natural sub-module: arb_wait_counter, the saturating starvation counter and force flag, also reused for conflict_cnt.
- The FSM, grant logic and rvalid tagging live in the top module.

Test Plan:
1. Lone core read at addr 5 (prewritten 64'hA5A5) → core_gnt_o same cycle, mem_cenb_o = 0, mem_wenb_o = 1; core_rvalid_o = 1 next cycle with core_rdata_o = 64'hA5A5; ext_rvalid_o stays 0.
2. Core and ext both request continuously, MAX_WAIT = 8 → core granted cycles 0–7, ext granted cycle 8, then core again; repeating pattern 8:1; conflict_cnt_o = 20 after 20 cycles.
3. ext write 64'h1234 to addr 9 on the same cycle as a core read of addr 3 → core wins. The ext write lands the next cycle, and a readback of addr 9 returns 64'h1234.
4. Core read granted, ext_lock_i raised the same cycle → core rvalid still pulses the next cycle. LOCK_PEND blocks the core; ack = 1 two cycles after the lock request; core_req held high gets no grant while locked.
5. Lock held, host bulk-writes 16 words, drops ext_lock_i → ack falls next edge; the pending core request is granted in the first SHARED cycle.
6. Assert rst_async_i between a read grant and the rvalid edge → no rvalid, all outputs at reset values immediately, FSM = SHARED after release.
